// File: rtl/calendar_alarm.sv
// calendar_alarm: programmable alarm driven by the calendar time-of-day counter.
// Snooze support (SNOOZE state, counters, MAX_SNOOZE) is built only with CALENDAR_ALARM_SNOOZE_EN.
module calendar_alarm #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Hours,
    input  logic [5:0] Mins,
    input  logic [5:0] Secs,
    input  logic       SetEn,
    input  logic [5:0] SetHours,
    input  logic [5:0] SetMins,
    input  logic       ArmEn,
    input  logic       Ack,
    input  logic       Snooze,
    output logic       Alarm,
    output logic       Snoozing,
    output logic [5:0] AlarmHours,
    output logic [5:0] AlarmMins,
    output logic       SetErr
);

    localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic [5:0]    hrs_q, hrs_d;
    logic [5:0]    mins_q, mins_d;
    logic          err_q, err_d;
    logic          alarm_q;
    logic          load_ok, load_bad;
    logic          match, ring_done;

    assign load_ok   = SetEn && (SetHours <= 6'd23) && (SetMins <= 6'd59);
    assign load_bad  = SetEn && !load_ok;
    assign match     = ArmEn && (Hours == hrs_q) && (Mins == mins_q)
                       && (Secs == 6'd0);
    assign ring_done = (ring_cnt_q == RW'(RING_SECS - 1));

`ifdef CALENDAR_ALARM_SNOOZE_EN
    localparam int SW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;
    localparam int CW = $clog2(MAX_SNOOZE + 1);

    logic [SW-1:0] ivl_q, ivl_d;
    logic [CW-1:0] snz_cnt_q, snz_cnt_d;
    logic          snz_ok, ivl_done;
    logic          snoozing_q;

    assign snz_ok   = Snooze && (snz_cnt_q < CW'(MAX_SNOOZE));
    assign ivl_done = (ivl_q == SW'(SNOOZE_SECS - 1));
`else
    localparam int unused_cfg = SNOOZE_SECS + MAX_SNOOZE;
    logic unused_snooze;
    assign unused_snooze = Snooze;
`endif

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        hrs_d      = hrs_q;
        mins_d     = mins_q;
        err_d      = load_bad;
`ifdef CALENDAR_ALARM_SNOOZE_EN
        ivl_d      = ivl_q;
        snz_cnt_d  = snz_cnt_q;
`endif
        // A valid load outranks any match or ring activity this cycle.
        if (load_ok) begin
            hrs_d   = SetHours;
            mins_d  = SetMins;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (match) begin
                        state_d    = RING;
                        ring_cnt_d = '0;
                    end
                end
                RING: begin
                    if (!ArmEn || Ack) begin
                        state_d = IDLE;
`ifdef CALENDAR_ALARM_SNOOZE_EN
                    end else if (snz_ok) begin
                        state_d   = SNOOZE;
                        snz_cnt_d = snz_cnt_q + CW'(1);
                        ivl_d     = '0;
`endif
                    end else if (ring_done) begin
                        state_d = IDLE;
                    end else begin
                        ring_cnt_d = ring_cnt_q + RW'(1);
                    end
                end
`ifdef CALENDAR_ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (!ArmEn || Ack) begin
                        state_d = IDLE;
                    end else if (ivl_done) begin
                        state_d    = RING;
                        ring_cnt_d = '0;
                    end else begin
                        ivl_d = ivl_q + SW'(1);
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
`ifdef CALENDAR_ALARM_SNOOZE_EN
        if (state_d == IDLE) snz_cnt_d = '0;
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            hrs_q      <= '0;
            mins_q     <= '0;
            err_q      <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            hrs_q      <= hrs_d;
            mins_q     <= mins_d;
            err_q      <= err_d;
            alarm_q    <= (state_d == RING);
        end
    end

`ifdef CALENDAR_ALARM_SNOOZE_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ivl_q      <= '0;
            snz_cnt_q  <= '0;
            snoozing_q <= 1'b0;
        end else begin
            ivl_q      <= ivl_d;
            snz_cnt_q  <= snz_cnt_d;
            snoozing_q <= (state_d == SNOOZE);
        end
    end

    assign Snoozing = snoozing_q;
`else
    assign Snoozing = 1'b0;
`endif

    assign Alarm      = alarm_q;
    assign AlarmHours = hrs_q;
    assign AlarmMins  = mins_q;
    assign SetErr     = err_q;

endmodule
